fifo_sync_ctrl: RTL and testbench
=================================

Name: fifo_sync_ctrl

Overview:
- Single-clock synchronous FIFO: 32 words x 8 bits, with first-word-fall-through output.
- Reports full/empty flags (active-low) and a word-count output.
- Provides a synchronous clear and two debug outputs showing the control state machine state.
- General-purpose buffer between a byte producer and a byte consumer in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 5, pointer width; DEPTH = 2**ADDR_W = 32 words.

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous reset, active-low.
- CLEAR_N  in  1  synchronous clear, active-low.
- WRITE  in  1  write request; one word is written per rising edge while high.
- READ  in  1  read request; one word is popped per rising edge while high.
- DATA_IN  in  DATA_W  write data, sampled on the rising edge.
- DATA_OUT  out  DATA_W  head-of-FIFO word (combinational from memory).
- F_FULL_N  out  1  low when 32 words are stored.
- F_EMPTY_N  out  1  low when 0 words are stored.
- USE_DW  out  ADDR_W  stored-word count modulo 32.
- state  out  2  current FSM state (debug).
- nextstate  out  2  next FSM state (debug).

Behaviour:
- **Storage:** 32x8 memory with synchronous write and asynchronous read. Write pointer wp and read pointer rp are ADDR_W bits each and wrap naturally from 31 to 0.
- **FSM states:** EMPTY=2'd0, PARTIAL=2'd1, FULL=2'd2. Code 2'd3 is illegal and recovers to EMPTY. "state" is the registered state; "nextstate" is the combinational next state.
- **Reset (RESET_N=0, asynchronous):**
  - wp=0, rp=0, count=0, state=EMPTY.
  - Outputs: F_EMPTY_N=0, F_FULL_N=1, USE_DW=0, DATA_OUT=0.
  - Memory contents are not reset.
- **Clear (CLEAR_N=0 at a rising edge):** same register effect as reset. Clear has priority over READ and WRITE.
- **Effective operations:**
  - Effective write = WRITE & (state!=FULL | READ).
  - Effective read = READ & (state!=EMPTY).
- **Write:** stores mem[wp] <= DATA_IN, then wp++.
- **Read:** rp++. The popped word is the value DATA_OUT presented during that cycle, before the edge.
- **Count:** an internal 6-bit count goes +1 on write only, -1 on read only, and is unchanged when both or neither occur. USE_DW = count[4:0], so USE_DW reads 0 when the FIFO is full; F_FULL_N disambiguates.
- **Flags:** F_EMPTY_N = (state!=EMPTY); F_FULL_N = (state!=FULL). Both are registered and update on the same edge as count.
- **DATA_OUT:**
  - Equals mem[rp] while not EMPTY.
  - Forced to 0 while EMPTY.
  - After a write into an empty FIFO, DATA_OUT shows the word from the next edge on (1-cycle write-to-read latency).
- **FSM transitions:**
  - EMPTY -> PARTIAL on an effective write.
  - PARTIAL -> EMPTY on read-only when count==1.
  - PARTIAL -> FULL on write-only when count==31.
  - FULL -> PARTIAL on read-only.
  - Otherwise the state holds.
- **Boundary cases:**
  - READ while EMPTY is ignored; no pointer or count change.
  - WRITE-only while FULL is ignored; data is dropped and memory is unchanged.
  - READ+WRITE while EMPTY: only the write occurs.
  - READ+WRITE while FULL: both occur; the FIFO stays FULL with count 32.
  - READ+WRITE while PARTIAL: both occur; count is unchanged.
- **Reset mid-operation:** aborts immediately and returns to the reset values above.

Decomposition:
- **Package fifo_pkg:**
  - DATA_W=8, ADDR_W=5, DEPTH=32.
  - Typedef fifo_state_t (2-bit enum EMPTY, PARTIAL, FULL).
  - Typedefs data_t and ptr_t.
- **Sub-module fifo_ram:** 32x8 dual-port RAM with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr -> rdata). All pointer, count and FSM logic stays in fifo_sync_ctrl.

Test Plan:
1. **Empty read:** reset, then hold READ=1 with WRITE=0 for 2 cycles -> F_EMPTY_N=0, F_FULL_N=1, USE_DW=0, DATA_OUT=0.
2. **Single write/read:** write 8'hA5 for one cycle -> next edge USE_DW=1, F_EMPTY_N=1, DATA_OUT=8'hA5. Then READ one cycle -> USE_DW=0, F_EMPTY_N=0.
3. **Fill and order:** write 0..31 -> after the 32nd write F_FULL_N=0 and USE_DW=0. A 33rd write of 8'hFF is ignored. Reading 32 words returns 0..31 in order, then F_EMPTY_N=0.
4. **Wrap-around:** write 20 words, read 20, write 20, read 20 -> data is in order, count is correct at each step, and pointers wrap past 31.
5. **Simultaneous read/write:** with 5 words stored, READ+WRITE for 10 cycles -> USE_DW stays 5 and data order is preserved. With the FIFO full, READ+WRITE for 1 cycle -> stays full and the head advances by one.
6. **Clear and reset:** with 10 words stored, CLEAR_N=0 for one edge -> USE_DW=0, state=EMPTY. Write 3 words, then pulse RESET_N low mid-cycle -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing, types and FSM encoding for the 32x8 synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram #(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W,
  parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [1 << ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock first-word-fall-through FIFO controller: pointers, word count,
// EMPTY/PARTIAL/FULL state machine and active-low flags around fifo_ram.
module fifo_sync_ctrl #(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W,
  parameter int unsigned ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              CLEAR_N,
  input  logic              WRITE,
  input  logic              READ,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              F_FULL_N,
  output logic              F_EMPTY_N,
  output logic [ADDR_W-1:0] USE_DW,
  output logic [1:0]        state,
  output logic [1:0]        nextstate
);

  import fifo_pkg::*;

  localparam int unsigned     LP_DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LP_CNT_LAST  = (ADDR_W+1)'(LP_DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_rp;
  logic [ADDR_W:0]   r_count;
  fifo_state_t       r_state;
  fifo_state_t       w_next;
  logic              w_wr;
  logic              w_rd;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  // A write into a full FIFO is accepted only when a read frees a slot on the same edge.
  assign w_wr = WRITE & ((r_state != FULL) | READ);
  assign w_rd = READ & (r_state != EMPTY);
  assign w_we = w_wr & CLEAR_N;

  always_comb begin
    w_next = r_state;
    if (!CLEAR_N) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_wr) w_next = PARTIAL;
        end
        PARTIAL: begin
          if (w_rd && !w_wr && r_count == LP_CNT_ONE) begin
            w_next = EMPTY;
          end else if (w_wr && !w_rd && r_count == LP_CNT_LAST) begin
            w_next = FULL;
          end
        end
        FULL: begin
          if (w_rd && !w_wr) w_next = PARTIAL;
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_state <= EMPTY;
    end else if (!CLEAR_N) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_state <= EMPTY;
    end else begin
      if (w_wr) r_wp <= r_wp + LP_PTR_ONE;
      if (w_rd) r_rp <= r_rp + LP_PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_state <= w_next;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (CLOCK),
    .i_we    (w_we),
    .i_waddr (r_wp),
    .i_wdata (DATA_IN),
    .i_raddr (r_rp),
    .o_rdata (w_rdata)
  );

  assign DATA_OUT  = (r_state == EMPTY) ? '0 : w_rdata;
  assign F_EMPTY_N = (r_state != EMPTY);
  assign F_FULL_N  = (r_state != FULL);
  assign USE_DW    = r_count[ADDR_W-1:0];
  assign state     = r_state;
  assign nextstate = w_next;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl against a queue-based FIFO model.
module tb_fifo_sync_ctrl;

  logic       CLOCK;
  logic       RESET_N;
  logic       CLEAR_N;
  logic       WRITE;
  logic       READ;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       F_FULL_N;
  logic       F_EMPTY_N;
  logic [4:0] USE_DW;
  logic [1:0] state;
  logic [1:0] nextstate;

  int unsigned n_vec;
  int unsigned n_err;
  logic [7:0]  q[$];
  logic [1:0]  ns_obs;
  logic [1:0]  ns_exp;
  logic [16:0] w_obs;

  fifo_sync_ctrl #(
    .DATA_W (8),
    .ADDR_W (5)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .CLEAR_N   (CLEAR_N),
    .WRITE     (WRITE),
    .READ      (READ),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .F_FULL_N  (F_FULL_N),
    .F_EMPTY_N (F_EMPTY_N),
    .USE_DW    (USE_DW),
    .state     (state),
    .nextstate (nextstate)
  );

  assign w_obs = {F_EMPTY_N, F_FULL_N, USE_DW, DATA_OUT, state};

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Occupancy after applying one request to a FIFO holding n words.
  function automatic int size_after(input int n, input logic wr, input logic rd, input logic clr);
    int ew, er;
    if (clr) return 0;
    ew = (wr && (n < 32 || rd)) ? 1 : 0;
    er = (rd && n > 0) ? 1 : 0;
    return n + ew - er;
  endfunction

  function automatic logic [1:0] state_of(input int n);
    return (n == 0) ? 2'd0 : (n == 32) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [16:0] exp_vec();
    int n;
    logic [7:0] head;
    logic [4:0] cnt;
    n    = q.size();
    head = (n > 0) ? q[0] : 8'h00;
    cnt  = 5'(n % 32);
    return {n != 0, n != 32, cnt, head, state_of(n)};
  endfunction

  // Applies one clock of stimulus from a falling edge to the next falling edge.
  task automatic cyc(input logic wr, input logic rd, input logic clr, input logic [7:0] d);
    int n;
    WRITE = wr; READ = rd; CLEAR_N = ~clr; DATA_IN = d;
    #1;
    ns_obs = nextstate;
    ns_exp = state_of(size_after(q.size(), wr, rd, clr));
    @(posedge CLOCK);
    n = q.size();
    if (clr) begin
      q.delete();
    end else begin
      if (rd && n > 0) void'(q.pop_front());
      if (wr && (n < 32 || rd)) q.push_back(d);
    end
    @(negedge CLOCK);
    WRITE = 1'b0; READ = 1'b0; CLEAR_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; CLEAR_N = 1'b1; WRITE = 1'b0; READ = 1'b0; DATA_IN = 8'h00;
    repeat (2) @(negedge CLOCK);
    q.delete();
    n_vec++;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL reset obs=%h exp=%h", w_obs, exp_vec());
    end
    RESET_N = 1'b1;
    @(negedge CLOCK);
    n_vec++;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_release obs=%h exp=%h", w_obs, exp_vec());
    end
  endtask

  task automatic test_empty_read();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h5A);
      n_vec++;
      if (w_obs !== exp_vec() || w_obs !== 17'h08000) begin
        n_err++; $display("FAIL empty_read[%0d] obs=%h exp=%h", i, w_obs, 17'h08000);
      end
    end
  endtask

  task automatic test_single();
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    n_vec++;
    if (w_obs !== exp_vec() || DATA_OUT !== 8'hA5 || USE_DW !== 5'd1) begin
      n_err++; $display("FAIL single_write obs=%h exp=%h", w_obs, exp_vec());
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    n_vec++;
    if (w_obs !== exp_vec() || F_EMPTY_N !== 1'b0) begin
      n_err++; $display("FAIL single_read obs=%h exp=%h", w_obs, exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i));
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL fill_wr[%0d] obs=%h exp=%h", i, w_obs, exp_vec());
      end
    end
    n_vec++;
    if (F_FULL_N !== 1'b0 || USE_DW !== 5'd0) begin
      n_err++; $display("FAIL fill_full full_n=%b use_dw=%0d exp 0/0", F_FULL_N, USE_DW);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'hFF);
    n_vec++;
    if (w_obs !== exp_vec() || DATA_OUT !== 8'h00) begin
      n_err++; $display("FAIL fill_overflow obs=%h exp=%h", w_obs, exp_vec());
    end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (DATA_OUT !== 8'(i)) begin
        n_err++; $display("FAIL fill_order[%0d] data=%h exp=%h", i, DATA_OUT, 8'(i));
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL fill_rd[%0d] obs=%h exp=%h", i, w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) begin
        cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
        n_vec++;
        if (w_obs !== exp_vec()) begin
          n_err++; $display("FAIL wrap_wr[%0d.%0d] obs=%h exp=%h", r, i, w_obs, exp_vec());
        end
      end
      for (int i = 0; i < 20; i++) begin
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        n_vec++;
        if (w_obs !== exp_vec()) begin
          n_err++; $display("FAIL wrap_rd[%0d.%0d] obs=%h exp=%h", r, i, w_obs, exp_vec());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'($urandom));
      n_vec++;
      if (w_obs !== exp_vec() || USE_DW !== 5'd5 || ns_obs !== ns_exp) begin
        n_err++; $display("FAIL rw_partial[%0d] obs=%h exp=%h ns=%0d/%0d", i, w_obs, exp_vec(), ns_obs, ns_exp);
      end
    end
    while (q.size() < 32) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    cyc(1'b1, 1'b1, 1'b0, 8'hC3);
    n_vec++;
    if (w_obs !== exp_vec() || F_FULL_N !== 1'b0 || ns_obs !== ns_exp) begin
      n_err++; $display("FAIL rw_full obs=%h exp=%h ns=%0d/%0d", w_obs, exp_vec(), ns_obs, ns_exp);
    end
  endtask

  task automatic test_clear();
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    n_vec++;
    if (w_obs !== exp_vec() || state !== 2'd0 || USE_DW !== 5'd0 || ns_obs !== ns_exp) begin
      n_err++; $display("FAIL clear obs=%h exp=%h ns=%0d/%0d", w_obs, exp_vec(), ns_obs, ns_exp);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    n_vec++;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL pre_reset obs=%h exp=%h", w_obs, exp_vec());
    end
    WRITE = 1'b1; DATA_IN = 8'h99;
    @(posedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    q.delete();
    n_vec++;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL async_reset obs=%h exp=%h", w_obs, exp_vec());
    end
    @(negedge CLOCK);
    WRITE = 1'b0;
    RESET_N = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    n_vec++;
    if (w_obs !== exp_vec()) begin
      n_err++; $display("FAIL post_reset obs=%h exp=%h", w_obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int unsigned pw [4] = '{80, 20, 50, 95};
    logic wr, rd, clr;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 100; i++) begin
        wr  = ($urandom_range(99) < pw[ph]);
        rd  = ($urandom_range(99) < (100 - pw[ph] + 5));
        clr = (ph == 2) && ($urandom_range(31) == 0);
        cyc(wr, rd, clr, 8'($urandom));
        n_vec++;
        if (w_obs !== exp_vec() || ns_obs !== ns_exp) begin
          n_err++; $display("FAIL random[%0d.%0d] obs=%h exp=%h ns=%0d/%0d", ph, i, w_obs, exp_vec(), ns_obs, ns_exp);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_empty_read();
    test_single();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
